// File: rtl/dpram_param.sv
// Parametrised true dual-port synchronous RAM with byte enables, read-valid strobes,
// deterministic collision handling and a hardware clear sweep after reset.
// Optional second output register stage: define DPRAM_PARAM_OUT_REG_EN.
module dpram_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   data_in_a,
    input  logic [DATA_W-1:0]   data_in_b,
    input  logic                we_a,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic                re_a,
    input  logic                re_b,
    output logic [DATA_W-1:0]   data_out_a,
    output logic [DATA_W-1:0]   data_out_b,
    output logic                valid_a,
    output logic                valid_b,
    output logic                collision,
    output logic                init_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                same_addr;
    logic [BE_W-1:0]     lanes_a;
    logic [BE_W-1:0]     lanes_b;
    logic [DATA_W-1:0]   mask_a;
    logic [DATA_W-1:0]   mask_b;
    logic [DATA_W-1:0]   old_a;
    logic [DATA_W-1:0]   old_b;
    logic [DATA_W-1:0]   merged_a;
    logic [DATA_W-1:0]   merged_b;
    logic [DATA_W-1:0]   merged_ab;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;

    logic [DATA_W-1:0]   dout1_a;
    logic [DATA_W-1:0]   dout1_b;
    logic                vld1_a;
    logic                vld1_b;

    assign run       = (state == RUN);
    assign same_addr = (addr_a == addr_b);

    // Init sweep: one address cleared per edge, RUN entered on the edge clearing the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (&sweep_cnt) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Port A owns every lane it enables; port B only lands in the remaining lanes on a shared address.
    always_comb begin
        lanes_a = '0;
        lanes_b = '0;
        if (run && we_a) lanes_a = be_a;
        if (run && we_b) lanes_b = be_b;
        if (same_addr) lanes_b = lanes_b & ~lanes_a;
    end

    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask_a[8*i +: 8] = {8{lanes_a[i]}};
            mask_b[8*i +: 8] = {8{lanes_b[i]}};
        end
    end

    always_comb begin
        old_a     = mem[addr_a];
        old_b     = mem[addr_b];
        merged_a  = (old_a & ~mask_a) | (data_in_a & mask_a);
        merged_b  = (old_b & ~mask_b) | (data_in_b & mask_b);
        merged_ab = (merged_a & ~mask_b) | (data_in_b & mask_b);
        // Cross-port reads always see old contents; only the port's own write may be forwarded.
        rd_a      = (RDW_MODE == 1) ? merged_a : old_a;
        rd_b      = (RDW_MODE == 1) ? merged_b : old_b;
    end

    // Storage has no reset; it is cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[sweep_cnt] <= '0;
        end else begin
            if (|lanes_a) mem[addr_a] <= merged_a;
            if (|lanes_b) mem[addr_b] <= (same_addr && (|lanes_a)) ? merged_ab : merged_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1_a   <= '0;
            dout1_b   <= '0;
            vld1_a    <= 1'b0;
            vld1_b    <= 1'b0;
            collision <= 1'b0;
        end else begin
            vld1_a    <= run && re_a;
            vld1_b    <= run && re_b;
            collision <= run && we_a && we_b && same_addr && (|be_a) && (|be_b);
            if (run && re_a) dout1_a <= rd_a;
            if (run && re_b) dout1_b <= rd_b;
        end
    end

`ifdef DPRAM_PARAM_OUT_REG_EN
    logic [DATA_W-1:0] dout2_a;
    logic [DATA_W-1:0] dout2_b;
    logic              vld2_a;
    logic              vld2_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout2_a <= '0;
            dout2_b <= '0;
            vld2_a  <= 1'b0;
            vld2_b  <= 1'b0;
        end else begin
            vld2_a <= vld1_a;
            vld2_b <= vld1_b;
            if (vld1_a) dout2_a <= dout1_a;
            if (vld1_b) dout2_b <= dout1_b;
        end
    end

    assign data_out_a = dout2_a;
    assign data_out_b = dout2_b;
    assign valid_a    = vld2_a;
    assign valid_b    = vld2_b;
`else
    assign data_out_a = dout1_a;
    assign data_out_b = dout1_b;
    assign valid_a    = vld1_a;
    assign valid_b    = vld1_b;
`endif

endmodule

// File: tb/tb_dpram_param.sv
// Self-checking bench for dpram_param: directed scenarios plus randomized traffic
// against a word-array reference model.
module tb_dpram_param;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int RDW_MODE = 0;
    localparam int BE_W     = DATA_W / 8;
    localparam int DEPTH    = 2 ** ADDR_W;
`ifdef DPRAM_PARAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_in_a, data_in_b;
    logic              we_a, we_b;
    logic [BE_W-1:0]   be_a, be_b;
    logic              re_a, re_b;
    logic [DATA_W-1:0] data_out_a, data_out_b;
    logic              valid_a, valid_b;
    logic              collision;
    logic              init_busy;

    dpram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .data_in_a  (data_in_a),
        .data_in_b  (data_in_b),
        .we_a       (we_a),
        .we_b       (we_b),
        .be_a       (be_a),
        .be_b       (be_b),
        .re_a       (re_a),
        .re_b       (re_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .valid_a    (valid_a),
        .valid_b    (valid_b),
        .collision  (collision),
        .init_busy  (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0] model [DEPTH];
    // Expected results as they emerge after 1 and 2 output stages.
    logic              e1_va, e1_vb, e2_va, e2_vb;
    logic [DATA_W-1:0] e1_da, e1_db, e2_da, e2_db;

    function automatic logic [DATA_W-1:0] expand(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        e1_va = 1'b0; e1_vb = 1'b0; e2_va = 1'b0; e2_vb = 1'b0;
        e1_da = '0;   e1_db = '0;   e2_da = '0;   e2_db = '0;
    endtask

    task automatic step(input logic wa, input logic ra, input logic [ADDR_W-1:0] aa,
                        input logic [DATA_W-1:0] da, input logic [BE_W-1:0] ba,
                        input logic wb, input logic rb, input logic [ADDR_W-1:0] ab,
                        input logic [DATA_W-1:0] db, input logic [BE_W-1:0] bb);
        logic [DATA_W-1:0] ma, mb, mb_eff, rda, rdb, exp_da, exp_db;
        logic              coll, exp_va, exp_vb;
        we_a = wa; re_a = ra; addr_a = aa; data_in_a = da; be_a = ba;
        we_b = wb; re_b = rb; addr_b = ab; data_in_b = db; be_b = bb;
        ma     = wa ? expand(ba) : '0;
        mb     = wb ? expand(bb) : '0;
        mb_eff = (aa == ab) ? (mb & ~ma) : mb;
        rda    = (RDW_MODE == 1) ? ((model[aa] & ~ma) | (da & ma)) : model[aa];
        rdb    = (RDW_MODE == 1) ? ((model[ab] & ~mb_eff) | (db & mb_eff)) : model[ab];
        coll   = wa && wb && (aa == ab) && (ba != '0) && (bb != '0);
        // B applied first so that A overwrites it on any shared lane.
        model[ab] = (model[ab] & ~mb) | (db & mb);
        model[aa] = (model[aa] & ~ma) | (da & ma);
        @(posedge clk);
        #1;
        if (e1_va) e2_da = e1_da;
        if (e1_vb) e2_db = e1_db;
        e2_va = e1_va; e2_vb = e1_vb;
        e1_va = ra;    e1_vb = rb;
        if (ra) e1_da = rda;
        if (rb) e1_db = rdb;
        exp_da = (LAT == 1) ? e1_da : e2_da;
        exp_db = (LAT == 1) ? e1_db : e2_db;
        exp_va = (LAT == 1) ? e1_va : e2_va;
        exp_vb = (LAT == 1) ? e1_vb : e2_vb;
        vectors += 6;
        if (data_out_a !== exp_da) begin
            miscompares++;
            $display("FAIL data_out_a t=%0t got %h expected %h", $time, data_out_a, exp_da);
        end
        if (data_out_b !== exp_db) begin
            miscompares++;
            $display("FAIL data_out_b t=%0t got %h expected %h", $time, data_out_b, exp_db);
        end
        if (valid_a !== exp_va) begin
            miscompares++;
            $display("FAIL valid_a t=%0t got %b expected %b", $time, valid_a, exp_va);
        end
        if (valid_b !== exp_vb) begin
            miscompares++;
            $display("FAIL valid_b t=%0t got %b expected %b", $time, valid_b, exp_vb);
        end
        if (collision !== coll) begin
            miscompares++;
            $display("FAIL collision t=%0t got %b expected %b", $time, collision, coll);
        end
        if (init_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL init_busy_run t=%0t got %b expected 0", $time, init_busy);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        we_a = 0; re_a = 0; addr_a = '0; data_in_a = '0; be_a = '0;
        we_b = 0; re_b = 0; addr_b = '0; data_in_b = '0; be_b = '0;
        repeat (hold) @(posedge clk);
        #1;
        vectors += 4;
        if ({data_out_a, data_out_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got %h/%h expected 0/0", data_out_a, data_out_b);
        end
        if ({valid_a, valid_b} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valid got %b%b expected 00", valid_a, valid_b);
        end
        if (collision !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_collision got %b expected 0", collision);
        end
        if (init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_init_busy got %b expected 1", init_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic check_sweep();
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < DEPTH + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n != DEPTH) begin
            miscompares++;
            $display("FAIL sweep_length got %0d cycles expected %0d", n, DEPTH);
        end
    endtask

    task automatic test_reset();
        apply_reset(3);
        check_sweep();
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, ADDR_W'(i), '0, '0, 0, 1, ADDR_W'(DEPTH - 1 - i), '0, '0);
        idle(LAT + 1);
    endtask

    task automatic test_mid_reset();
        step(1, 0, ADDR_W'(5), DATA_W'(32'h12345678), '1, 0, 0, '0, '0, '0);
        apply_reset(2);
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_sweep_busy got %b expected 1", init_busy);
        end
        apply_reset(2);
        check_sweep();
        step(0, 1, ADDR_W'(5), '0, '0, 0, 0, '0, '0, '0);
        idle(LAT - 1);
        vectors++;
        if (data_out_a !== '0) begin
            miscompares++;
            $display("FAIL cleared_after_reset got %h expected 0", data_out_a);
        end
        idle(1);
    endtask

    task automatic test_dual_write();
        step(1, 0, ADDR_W'(3), DATA_W'(32'h98B7FDA4), '1, 1, 0, ADDR_W'(10), DATA_W'(32'hFACECAFE), '1);
        step(0, 1, ADDR_W'(3), '0, '0, 0, 1, ADDR_W'(10), '0, '0);
        idle(LAT - 1);
        vectors += 2;
        if (data_out_a !== DATA_W'(32'h98B7FDA4) || data_out_b !== DATA_W'(32'hFACECAFE)) begin
            miscompares++;
            $display("FAIL dual_write_data got %h/%h expected 98b7fda4/facecafe", data_out_a, data_out_b);
        end
        if ({valid_a, valid_b} !== 2'b11) begin
            miscompares++;
            $display("FAIL dual_write_valid got %b%b expected 11", valid_a, valid_b);
        end
        idle(1);
    endtask

    task automatic test_collision();
        step(1, 0, ADDR_W'(15), DATA_W'(32'h11223344), '1, 0, 0, '0, '0, '0);
        step(1, 0, ADDR_W'(15), DATA_W'(32'hCAFEBABE), BE_W'(4'b0011),
             1, 0, ADDR_W'(15), DATA_W'(32'hDEADBEEF), BE_W'(4'b1111));
        step(0, 1, ADDR_W'(15), '0, '0, 0, 0, '0, '0, '0);
        idle(LAT - 1);
        vectors++;
        if (data_out_a !== DATA_W'(32'hDEADBABE)) begin
            miscompares++;
            $display("FAIL collision_merge got %h expected deadbabe", data_out_a);
        end
        // Write enable with no lanes must not count as a collision.
        step(1, 0, ADDR_W'(15), DATA_W'(32'h0), '0, 1, 0, ADDR_W'(15), DATA_W'(32'h55555555), '1);
        idle(1);
    endtask

    task automatic test_rdw();
        logic [DATA_W-1:0] exp_a;
        step(1, 0, ADDR_W'(7), '0, '1, 0, 0, '0, '0, '0);
        step(1, 1, ADDR_W'(7), DATA_W'(32'hA5A5A5A5), '1, 0, 1, ADDR_W'(7), '0, '0);
        idle(LAT - 1);
        exp_a = (RDW_MODE == 1) ? DATA_W'(32'hA5A5A5A5) : '0;
        vectors += 2;
        if (data_out_a !== exp_a) begin
            miscompares++;
            $display("FAIL rdw_same_port got %h expected %h", data_out_a, exp_a);
        end
        if (data_out_b !== '0) begin
            miscompares++;
            $display("FAIL rdw_cross_port got %h expected 0", data_out_b);
        end
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
                 BE_W'($urandom),
                 1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
                 BE_W'($urandom));
        end
        idle(LAT + 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            step(1, 0, ADDR_W'(16 + i), DATA_W'($urandom), '1, 0, 0, '0, '0, '0);
        for (int i = 0; i < 8; i++)
            step(0, 1, ADDR_W'(16 + i), '0, '0, 0, 1, ADDR_W'(23 - i), '0, '0);
        idle(LAT + 1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        clear_model();
        test_reset();
        test_mid_reset();
        test_dual_write();
        test_collision();
        test_rdw();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
